// File: rtl/vga_pkg.sv
// Shared definitions for the VGA background path.
//   bg_fetch_state_e : fetch FSM state encoding
//   BG_*             : row layout in memory and size-word field positions
package vga_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StRd2,
    StCommit
  } bg_fetch_state_e;

  // Each background row is 3 words, placed on a 4-word stride.
  localparam int unsigned BG_WORDS_PER_ROW = 3;
  localparam int unsigned BG_ROW_STRIDE    = 4;

  // Size word layout: size_0 in [5:0], size_1 in [13:8].
  localparam int unsigned BG_SIZE0_LSB = 0;
  localparam int unsigned BG_SIZE1_LSB = 8;
  localparam int unsigned BG_SIZE_W    = 6;

endpackage

// File: rtl/vga_bg_row_tracker.sv
// Background row / line-in-row counters.
//   clk, reset     : clock, synchronous active-high reset
//   frame_start    : clears both counters and requests a fetch of row 0
//   line_end       : advances line_in_row; rolls over into the next row
//   bg_row_height  : lines per background row minus 1
//   fetch_req      : one-cycle request to fetch the row given by fetch_row
//   fetch_row      : row value the counters take at the coming clock edge
module vga_bg_row_tracker #(
  parameter int unsigned ROW_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             line_end,
  input  logic [3:0]       bg_row_height,
  output logic             fetch_req,
  output logic [ROW_W-1:0] fetch_row
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [3:0]       line_q, line_d;

  always_comb begin
    row_d     = row_q;
    line_d    = line_q;
    fetch_req = 1'b0;
    if (frame_start) begin
      // frame_start wins over a coincident line_end
      row_d     = '0;
      line_d    = '0;
      fetch_req = 1'b1;
    end else if (line_end) begin
      if (line_q == bg_row_height) begin
        line_d    = '0;
        row_d     = row_q + ROW_W'(1);
        fetch_req = 1'b1;
      end else begin
        line_d = line_q + 4'd1;
      end
    end
  end

  // Forward the next value so a fetch accepted this cycle uses the new row.
  assign fetch_row = row_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q  <= '0;
      line_q <= '0;
    end else begin
      row_q  <= row_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/vga_bg_fetcher.sv
// Background row fetcher: reads the 3-word row descriptor over a single-outstanding
// req/ack port into shadow registers and commits it to the renderer outputs only
// while h_active is low.
//   clk, reset          : clock, synchronous active-high reset
//   frame_start         : frame strobe, restarts at row 0 and clears underrun
//   line_end            : end-of-visible-line strobe
//   h_active            : horizontal active; commits wait for it to be low
//   bg_base             : word address of row 0
//   bg_row_height       : lines per background row minus 1
//   mem_req/addr        : registered read request and word address
//   mem_ack/rdata       : one-cycle acknowledge with data
//   bg_pixels_0/1       : committed pattern words
//   bg_size_0/1         : committed pixel-size fields
//   busy                : fetch in flight or commit/request pending
//   underrun            : sticky, h_active rose with a row change uncommitted
module vga_bg_fetcher
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ROW_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_end,
  input  logic              h_active,
  input  logic [ADDR_W-1:0] bg_base,
  input  logic [3:0]        bg_row_height,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       bg_pixels_0,
  output logic [31:0]       bg_pixels_1,
  output logic [5:0]        bg_size_0,
  output logic [5:0]        bg_size_1,
  output logic              busy,
  output logic              underrun
);

  logic             fetch_req;
  logic [ROW_W-1:0] fetch_row;
  logic [ADDR_W-1:0] row_addr;

  vga_bg_row_tracker #(
    .ROW_W(ROW_W)
  ) u_row_tracker (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .line_end     (line_end),
    .bg_row_height(bg_row_height),
    .fetch_req    (fetch_req),
    .fetch_row    (fetch_row)
  );

  assign row_addr = bg_base + ADDR_W'(fetch_row) * ADDR_W'(BG_ROW_STRIDE);

  bg_fetch_state_e   state_q, state_d;
  logic              pending_q, pending_d;
  logic              abort_q, abort_d;   // frame_start seen mid-handshake
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sh_pix0_q, sh_pix0_d;
  logic [31:0]       sh_pix1_q, sh_pix1_d;
  logic [5:0]        sh_size0_q, sh_size0_d;
  logic [5:0]        sh_size1_q, sh_size1_d;
  logic              commit;
  logic              h_active_q;
  logic              underrun_q, underrun_d;
  logic [31:0]       pix0_q, pix1_q;
  logic [5:0]        size0_q, size1_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    abort_d    = abort_q;
    addr_d     = addr_q;
    sh_pix0_d  = sh_pix0_q;
    sh_pix1_d  = sh_pix1_q;
    sh_size0_d = sh_size0_q;
    sh_size1_d = sh_size1_q;
    commit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fetch_req || pending_q) begin
          state_d   = StRd0;
          addr_d    = row_addr;
          pending_d = 1'b0;
        end
      end
      StRd0, StRd1, StRd2: begin
        if (fetch_req) pending_d = 1'b1;
        if (frame_start) abort_d = 1'b1;
        if (mem_ack) begin
          if (abort_q || frame_start) begin
            // Handshake done; drop its data and restart from the current row.
            state_d   = StRd0;
            addr_d    = row_addr;
            pending_d = 1'b0;
            abort_d   = 1'b0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (state_q == StRd0) begin
              sh_pix0_d = mem_rdata;
              state_d   = StRd1;
            end else if (state_q == StRd1) begin
              sh_pix1_d = mem_rdata;
              state_d   = StRd2;
            end else begin
              sh_size0_d = mem_rdata[BG_SIZE0_LSB +: BG_SIZE_W];
              sh_size1_d = mem_rdata[BG_SIZE1_LSB +: BG_SIZE_W];
              state_d    = StCommit;
            end
          end
        end
      end
      StCommit: begin
        if (frame_start) begin
          state_d   = StRd0;
          addr_d    = row_addr;
          pending_d = 1'b0;
        end else begin
          if (fetch_req) pending_d = 1'b1;
          if (!h_active) begin
            state_d = StIdle;
            commit  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    req_d = (state_d == StRd0) || (state_d == StRd1) || (state_d == StRd2);
  end

  always_comb begin
    underrun_d = underrun_q;
    if (frame_start) begin
      underrun_d = 1'b0;
    end else if (h_active && !h_active_q && ((state_q != StIdle) || pending_q)) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      abort_q    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      sh_pix0_q  <= '0;
      sh_pix1_q  <= '0;
      sh_size0_q <= '0;
      sh_size1_q <= '0;
      h_active_q <= 1'b0;
      underrun_q <= 1'b0;
      pix0_q     <= '0;
      pix1_q     <= '0;
      size0_q    <= '0;
      size1_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      abort_q    <= abort_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      sh_pix0_q  <= sh_pix0_d;
      sh_pix1_q  <= sh_pix1_d;
      sh_size0_q <= sh_size0_d;
      sh_size1_q <= sh_size1_d;
      h_active_q <= h_active;
      underrun_q <= underrun_d;
      if (commit) begin
        pix0_q  <= sh_pix0_q;
        pix1_q  <= sh_pix1_q;
        size0_q <= sh_size0_q;
        size1_q <= sh_size1_q;
      end
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign bg_pixels_0 = pix0_q;
  assign bg_pixels_1 = pix1_q;
  assign bg_size_0   = size0_q;
  assign bg_size_1   = size1_q;
  assign busy        = (state_q != StIdle) || pending_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_bg_fetcher.sv
// Self-checking bench for vga_bg_fetcher: directed scenarios plus randomized
// frames checked against a line-count model of which row should be on screen.
module tb_vga_bg_fetcher;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        line_end;
  logic        h_active;
  logic [15:0] bg_base;
  logic [3:0]  bg_row_height;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] bg_pixels_0;
  logic [31:0] bg_pixels_1;
  logic [5:0]  bg_size_0;
  logic [5:0]  bg_size_1;
  logic        busy;
  logic        underrun;

  vga_bg_fetcher #(
    .ADDR_W(16),
    .ROW_W (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .line_end     (line_end),
    .h_active     (h_active),
    .bg_base      (bg_base),
    .bg_row_height(bg_row_height),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .bg_pixels_0  (bg_pixels_0),
    .bg_pixels_1  (bg_pixels_1),
    .bg_size_0    (bg_size_0),
    .bg_size_1    (bg_size_1),
    .busy         (busy),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_ovr [logic [15:0]];
  logic [15:0] acks [$];
  bit          ack_random = 1'b0;
  int          ack_fixed  = 0;
  int          ack_max    = 0;
  int          rnd_delay  = 0;
  int          wait_cnt   = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    h = {a, a ^ 16'hA53C};
    h = h * 32'h9E37_79B1;
    return h ^ {h[15:0], h[31:16]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_le();
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int k = 0;
    while (acks.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, acks.size(), n);
  endtask

  task automatic wait_addr(input logic [15:0] a, input int budget, input string tag);
    int k = 0;
    while (!(mem_req && mem_addr == a) && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, {mem_req, mem_addr}, {1'b1, a});
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] a);
    logic [15:0] a1, a2;
    logic [31:0] w2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    w2 = mem_word(a2);
    check_eq({tag, ".p0"}, bg_pixels_0, mem_word(a));
    check_eq({tag, ".p1"}, bg_pixels_1, mem_word(a1));
    check_eq({tag, ".s0"}, 32'(bg_size_0), 32'(w2[5:0]));
    check_eq({tag, ".s1"}, 32'(bg_size_1), 32'(w2[13:8]));
  endtask

  // Memory responder: acks after a configurable number of wait cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && !reset) begin
        if (wait_cnt >= (ack_random ? rnd_delay : ack_fixed)) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          acks.push_back(mem_addr);
          wait_cnt  = 0;
          rnd_delay = $urandom_range(ack_max, 0);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n0;
    int          k;
    int          n_lines;
    int          rows_h;
    bit          fetch;
    logic [15:0] exp_addr;
    logic [7:0]  m_row;

    reset         = 1'b1;
    frame_start   = 1'b0;
    line_end      = 1'b0;
    h_active      = 1'b0;
    bg_base       = '0;
    bg_row_height = '0;
    mem_ovr[16'h0100] = 32'hA5A5_A5A5;
    mem_ovr[16'h0101] = 32'h0F0F_0F0F;
    mem_ovr[16'h0102] = 32'h0000_0203;
    tick(3);

    check_eq("rst.req", mem_req, 1'b0);
    check_eq("rst.addr", mem_addr, 16'h0);
    check_eq("rst.p0", bg_pixels_0, 32'h0);
    check_eq("rst.p1", bg_pixels_1, 32'h0);
    check_eq("rst.size", {bg_size_1, bg_size_0}, 12'h0);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.underrun", underrun, 1'b0);

    // Zero-wait fetch of row 0
    reset   = 1'b0;
    bg_base = 16'h0100;
    tick();
    pulse_fs();
    check_eq("t1.rd0", {mem_req, mem_addr}, {1'b1, 16'h0100});
    tick();
    check_eq("t1.rd1", {mem_req, mem_addr}, {1'b1, 16'h0101});
    tick();
    check_eq("t1.rd2", {mem_req, mem_addr}, {1'b1, 16'h0102});
    tick();
    check_eq("t1.cmt.req", mem_req, 1'b0);
    check_eq("t1.cmt.busy", busy, 1'b1);
    check_eq("t1.cmt.p0", bg_pixels_0, 32'h0);
    tick();
    check_eq("t1.p0", bg_pixels_0, 32'hA5A5_A5A5);
    check_eq("t1.p1", bg_pixels_1, 32'h0F0F_0F0F);
    check_eq("t1.s0", bg_size_0, 6'd3);
    check_eq("t1.s1", bg_size_1, 6'd2);
    check_eq("t1.busy", busy, 1'b0);

    // Two lines per row: fetches only on every second line_end
    bg_row_height = 4'd1;
    for (int i = 1; i <= 4; i++) begin
      n0 = acks.size();
      pulse_le();
      tick(8);
      check_eq($sformatf("t2.nacks%0d", i), acks.size() - n0, (i % 2 == 0) ? 3 : 0);
      if (i % 2 == 0) begin
        check_eq($sformatf("t2.addr%0d", i), acks[n0], (i == 2) ? 16'h0104 : 16'h0108);
      end
    end
    check_outputs("t2.row2", 16'h0108);

    // Slow memory, h_active rises mid-fetch
    ack_fixed = 20;
    pulse_le();
    tick(3);
    n0 = acks.size();
    pulse_le();
    wait_addr(16'h010D, 60, "t3.rd1");
    h_active = 1'b1;
    tick();
    check_eq("t3.underrun", underrun, 1'b1);
    check_outputs("t3.held", 16'h0108);
    wait_acks(n0 + 3, 80, "t3.nacks");
    tick(3);
    check_eq("t3.busy_cmt", busy, 1'b1);
    check_eq("t3.req_cmt", mem_req, 1'b0);
    check_outputs("t3.held2", 16'h0108);
    h_active = 1'b0;
    tick();
    check_outputs("t3.commit", 16'h010C);
    check_eq("t3.busy", busy, 1'b0);
    check_eq("t3.sticky", underrun, 1'b1);
    ack_fixed = 0;
    pulse_fs();
    check_eq("t3.fs_clr", underrun, 1'b0);
    tick(6);
    check_outputs("t3.row0", 16'h0100);

    // frame_start during RD1 with the ack still outstanding
    ack_fixed = 5;
    n0 = acks.size();
    pulse_fs();
    wait_addr(16'h0101, 30, "t5.rd1");
    pulse_fs();
    k = 0;
    while (acks.size() == n0 + 1 && k < 20) begin
      check_eq("t5.hold", {mem_req, mem_addr}, {1'b1, 16'h0101});
      tick();
      k++;
    end
    wait_acks(n0 + 5, 80, "t5.nacks");
    check_eq("t5.a1", acks[n0 + 1], 16'h0101);
    check_eq("t5.a2", acks[n0 + 2], 16'h0100);
    check_eq("t5.a3", acks[n0 + 3], 16'h0101);
    check_eq("t5.a4", acks[n0 + 4], 16'h0102);
    tick(3);
    check_outputs("t5.row0", 16'h0100);

    // Address wrap
    bg_base   = 16'hFFFE;
    ack_fixed = 0;
    n0 = acks.size();
    pulse_fs();
    wait_acks(n0 + 3, 20, "t6.nacks");
    check_eq("t6.a0", acks[n0], 16'hFFFE);
    check_eq("t6.a1", acks[n0 + 1], 16'hFFFF);
    check_eq("t6.a2", acks[n0 + 2], 16'h0000);
    tick(2);
    check_outputs("t6.out", 16'hFFFE);

    // Reset during a fetch drops the request at once
    ack_fixed = 30;
    pulse_fs();
    tick(2);
    check_eq("rst2.req_before", mem_req, 1'b1);
    reset = 1'b1;
    tick();
    check_eq("rst2.req", mem_req, 1'b0);
    check_eq("rst2.busy", busy, 1'b0);
    check_eq("rst2.p0", bg_pixels_0, 32'h0);
    reset = 1'b0;
    tick();

    // Randomized frames: row on screen = lines / (height + 1)
    ack_random = 1'b1;
    ack_max    = 3;
    rnd_delay  = 0;
    for (int f = 0; f < 3; f++) begin
      bg_row_height = 4'($urandom_range(3, 0));
      bg_base       = 16'($urandom);
      rows_h        = int'(bg_row_height) + 1;
      n_lines       = 0;
      exp_addr      = bg_base;
      n0 = acks.size();
      pulse_fs();
      tick(23);
      check_eq("rnd.fs_nacks", acks.size() - n0, 3);
      check_eq("rnd.fs_addr", acks[n0], exp_addr);
      check_outputs("rnd.fs", exp_addr);
      for (int i = 0; i < 20; i++) begin
        n0 = acks.size();
        if ($urandom_range(3, 0) == 0) bg_base = 16'($urandom);
        n_lines++;
        fetch = (n_lines % rows_h) == 0;
        if (fetch) begin
          m_row    = 8'(n_lines / rows_h);
          exp_addr = bg_base + 16'(m_row) * 16'd4;
        end
        pulse_le();
        tick(23);
        check_eq($sformatf("rnd.nacks f%0d l%0d", f, i), acks.size() - n0, fetch ? 3 : 0);
        if (fetch) check_eq($sformatf("rnd.addr f%0d l%0d", f, i), acks[n0], exp_addr);
        check_outputs($sformatf("rnd.out f%0d l%0d", f, i), exp_addr);
        check_eq("rnd.busy", busy, 1'b0);
        check_eq("rnd.underrun", underrun, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_bg_fetcher.md
# vga_bg_fetcher

Memory-side producer for the background renderer. Once per background row it fetches the two 16-pixel, 2-bpp pattern words and the per-half pixel-size word from memory over a single-outstanding req/ack read port. It commits them to the `bg_pixels_*` and `bg_size_*` outputs only while `h_active` is low, so the renderer never sees a mid-line change. It sits between the memory arbiter and the background renderer, and is driven by the timing generator's frame and line strobes.

## Interface
Parameters:
- `ADDR_W`, default 16: memory word-address width.
- `ROW_W`, default 8: background row counter width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `frame_start`, in, 1: one-cycle pulse before the first visible line of a frame.
- `line_end`, in, 1: one-cycle pulse at the `h_active` falling edge of each visible line.
- `h_active`, in, 1: horizontal active; commits are gated by it.
- `bg_base`, in, `ADDR_W`: word address of row 0.
- `bg_row_height`, in, 4: lines per background row minus 1.
- `mem_req`, out, 1: read request.
- `mem_addr`, out, `ADDR_W`: read word address.
- `mem_ack`, in, 1: one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`, in, 32: read data.
- `bg_pixels_0`, out, 32: pixels 0-15, MSB pair first.
- `bg_pixels_1`, out, 32: pixels 16-31.
- `bg_size_0`, out, 6: screen pixels per pattern pixel minus 1, first half.
- `bg_size_1`, out, 6: same, second half.
- `busy`, out, 1: fetch in progress or commit pending.
- `underrun`, out, 1: sticky; cleared by `reset` or `frame_start`.

## Operation
- Each row occupies 3 words at `bg_base + row*4`:
  - +0: pixels_0.
  - +1: pixels_1.
  - +2: size word, bits [5:0] = size_0, bits [13:8] = size_1; other bits ignored.
  - Address arithmetic wraps modulo 2^`ADDR_W`.
- Counters:
  - `row` (`ROW_W` bits) and `line_in_row` (4 bits).
  - `frame_start` clears both and requests a fetch of row 0.
  - `line_end`: if `line_in_row == bg_row_height`, clear `line_in_row`, increment `row` (wraps), and request a fetch. Otherwise increment `line_in_row` only.
- FSM states: IDLE, RD0, RD1, RD2, COMMIT.
  - IDLE → RD0 on a fetch request. The row address is latched at entry to RD0.
  - RDn holds `mem_req` high with its address and moves to the next state on `mem_ack`, capturing `mem_rdata` into the shadow register. Requests may be back-to-back.
  - RD2 ack → COMMIT.
  - COMMIT → IDLE in the first cycle with `h_active` low. In that cycle the shadows are copied to the outputs.
- Pending request:
  - A fetch request while not in IDLE sets a one-bit pending flag; repeated requests coalesce.
  - IDLE with pending set goes to RD0 using the current `row`.
- Underrun: set if `h_active` rises while a row change is uncommitted (state ≠ IDLE or pending set). The outputs keep their previous values.
- `frame_start` during RDn:
  - The current handshake completes; `mem_req` is never dropped before `mem_ack`.
  - Its data is discarded, then the FSM restarts at RD0 for row 0.
- `frame_start` during COMMIT: the shadows are discarded and the FSM goes to RD0 for row 0.
- `frame_start` and `line_end` in the same cycle: `frame_start` wins and `line_end` is ignored.
- `busy` = (state ≠ IDLE) or pending.

## Timing
- Reset values: all outputs 0, state IDLE, pending 0, counters 0.
- `mem_req` and `mem_addr` are registered and stable from assertion until the ack cycle.
- Fetch request at cycle T → `mem_req` high at T+1.
- Zero-wait memory (ack in the cycle after req assertion): RD0–RD2 take 3 cycles. With `h_active` low, the outputs update at T+5.
- A commit takes effect on the clock edge after COMMIT is entered with `h_active` low. There is no combinational path from `mem_rdata` to the outputs.
- `reset` mid-fetch: `mem_req` drops on the next cycle without waiting for ack. The arbiter treats reset as a port abort.

## Structure
- Shared `vga_pkg`:
  - Fetch state enum.
  - `BG_WORDS_PER_ROW = 3`, `BG_ROW_STRIDE = 4`.
  - Size-field bit offsets (0 and 8) and width (6).
- One sub-module, `vga_bg_row_tracker`:
  - Owns `row` and `line_in_row`.
  - Takes `frame_start`, `line_end` and `bg_row_height`.
  - Emits a one-cycle `fetch_req` and the current `row`.

## Test plan
- Reset, then `frame_start` with `bg_base = 0x0100` and zero-wait ack → addresses 0x0100, 0x0101, 0x0102 on consecutive cycles. With rdata A5A5A5A5, 0F0F0F0F, 0x0203 → `bg_pixels_0` = A5A5A5A5, `bg_pixels_1` = 0F0F0F0F, `bg_size_0` = 3, `bg_size_1` = 2.
- `bg_row_height = 1`; `line_end` ×4 → fetches at rows 1 and 2 (addresses 0x0104 and 0x0108 first words) only after the 2nd and 4th pulses.
- Ack delayed 20 cycles and `h_active` raised during RD1 → `underrun` = 1, outputs unchanged until `h_active` falls, then commit. `frame_start` clears `underrun`.
- Fetch completes while `h_active` = 1 → FSM waits in COMMIT with outputs held; they update exactly one edge after `h_active` falls.
- `frame_start` during RD1 with ack pending → `mem_req` held until ack, that data is discarded, and the next request is at `bg_base + 0`.
- `bg_base = 0xFFFE`, row 0 → addresses FFFE, FFFF, 0000.
